pc_unit: RTL

Program-counter and flags stage that sits directly upstream of the bottom decode ROM: it owns the registered `PC` and `NZVC` values the ROM consumes, advancing `PC` each cycle. It also evaluates conditional jumps against the held flags and keeps a small return-address stack for call/return. All state is registered on one clock.

---
 rtl/pc_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program counter, NZVC flags and return-address stack feeding the decode ROM.
// Every output is a flop; the next state is built in one combinational block.
module pc_unit #(
   parameter int PC_WIDTH    = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                stall,
   input  logic                jump,
   input  logic [2:0]          jcond,
   input  logic [PC_WIDTH-1:0] jaddr,
   input  logic                call,
   input  logic                ret,
   input  logic                flag_we,
   input  logic [3:0]          alu_flags,
   output logic [PC_WIDTH-1:0] PC,
   output logic [3:0]          NZVC,
   output logic                taken,
   output logic                stack_err
);

   localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(STACK_DEPTH);
   localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
   localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);

   typedef enum logic [2:0] {
      JC_ALWAYS = 3'd0,
      JC_Z      = 3'd1,
      JC_NZ     = 3'd2,
      JC_C      = 3'd3,
      JC_NC     = 3'd4,
      JC_N      = 3'd5,
      JC_V      = 3'd6,
      JC_NEVER  = 3'd7
   } jcond_e;

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [3:0]          nzvc_q, nzvc_d;
   logic                taken_q, taken_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

   logic [PC_WIDTH-1:0] pc_inc;
   logic [PTR_W-1:0]    wr_idx;
   logic [PTR_W-1:0]    top_idx;
   logic                stack_empty;
   logic                stack_full;
   logic                cond_true;
   logic                push_en;

   assign pc_inc      = pc_q + PC_ONE;
   assign stack_empty = (cnt_q == '0);
   assign stack_full  = (cnt_q == CNT_FULL);
   // When full the low pointer bits wrap to 0, so top_idx still lands on the last slot.
   assign wr_idx      = cnt_q[PTR_W-1:0];
   assign top_idx     = cnt_q[PTR_W-1:0] - PTR_ONE;

   // Conditions look only at the registered flags, never at same-cycle alu_flags.
   always_comb begin
      cond_true = 1'b0;
      unique case (jcond_e'(jcond))
         JC_ALWAYS: cond_true = 1'b1;
         JC_Z:      cond_true = nzvc_q[2];
         JC_NZ:     cond_true = ~nzvc_q[2];
         JC_C:      cond_true = nzvc_q[0];
         JC_NC:     cond_true = ~nzvc_q[0];
         JC_N:      cond_true = nzvc_q[3];
         JC_V:      cond_true = nzvc_q[1];
         JC_NEVER:  cond_true = 1'b0;
         default:   cond_true = 1'b0;
      endcase
   end

   always_comb begin
      pc_d    = pc_q;
      taken_d = 1'b0;
      err_d   = err_q;
      cnt_d   = cnt_q;
      push_en = 1'b0;
      nzvc_d  = flag_we ? alu_flags : nzvc_q;

      if (!stall) begin
         if (ret) begin
            if (!stack_empty) begin
               pc_d    = stack_q[top_idx];
               cnt_d   = cnt_q - CNT_ONE;
               taken_d = 1'b1;
            end else begin
               pc_d  = pc_inc;
               err_d = 1'b1;
            end
         end else if (call) begin
            if (!stack_full) begin
               push_en = 1'b1;
               pc_d    = jaddr;
               cnt_d   = cnt_q + CNT_ONE;
               taken_d = 1'b1;
            end else begin
               pc_d  = pc_inc;
               err_d = 1'b1;
            end
         end else if (jump && cond_true) begin
            pc_d    = jaddr;
            taken_d = 1'b1;
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q    <= '0;
         nzvc_q  <= '0;
         taken_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         nzvc_q  <= nzvc_d;
         taken_q <= taken_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Stack storage needs no reset: the count alone defines which entries are live.
   always_ff @(posedge clock) begin
      if (push_en) begin
         stack_q[wr_idx] <= pc_inc;
      end
   end

   assign PC        = pc_q;
   assign NZVC      = nzvc_q;
   assign taken     = taken_q;
   assign stack_err = err_q;

endmodule
